binary_to_bcd_serial: RTL

//   Multi-cycle shift-and-add-3 (double-dabble) converter from an unsigned binary count to packed BCD.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_adjust.sv | 19 +
 rtl/binary_to_bcd_serial.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared constants and FSM encoding for the serial binary-to-BCD converter.
//   Contents:
//     BCD_DIGIT_W     width of one BCD digit (nibble)
//     BCD_ADJ_THRESH  digit value at or above which the add-3 adjust applies
//     BCD_ADJ_ADD     adjust amount added before each shift
//     BCD_NINE        largest legal BCD digit, used for saturated output
//     bcd_state_e     converter FSM state encoding
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE       = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
//   Combinational double-dabble digit correction: a digit of 5 or more gets 3
//   added so that the following left shift carries correctly into the next
//   decimal digit. The sum stays within 4 bits; there is no carry out.
//   Ports:
//     digit_in   [3:0]  BCD digit before adjust
//     digit_out  [3:0]  BCD digit after adjust
// -----------------------------------------------------------------------------
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;

endmodule : bcd_digit_adjust

// File: rtl/binary_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_serial
//   Multi-cycle shift-and-add-3 (double-dabble) converter from an unsigned
//   binary value to packed BCD, one input bit per clock.
//   Ports:
//     Clock          rising-edge clock
//     Reset_N        asynchronous active-low reset
//     Start          conversion request, sampled only while Busy=0
//     Binary_Number  unsigned input value, captured on the accepting edge
//     Busy           conversion in progress
//     Done           one-cycle pulse; BCD_Number/Overflow valid and held
//     BCD_Number     packed BCD, most-significant digit in the top nibble
//     Overflow       captured value was >= 10**DIGITS
//   Build option:
//     BCD_SATURATE_EN  when defined, an overflowing result is replaced by all
//                      nines; otherwise the value modulo 10**DIGITS is output.
// -----------------------------------------------------------------------------
module binary_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 2
) (
  input  logic                          Clock,
  input  logic                          Reset_N,
  input  logic                          Start,
  input  logic [BIN_WIDTH-1:0]          Binary_Number,
  output logic                          Busy,
  output logic                          Done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_Number,
  output logic                          Overflow
);

  localparam int                BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int                REG_W     = BCD_W + BIN_WIDTH;
  localparam int                CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BIN_WIDTH - 1);
  localparam logic [31:0]       BCD_LIMIT = 32'(10 ** DIGITS);

  bcd_state_e         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [REG_W-1:0]   shift_reg;
  logic               ovf_flag_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               overflow_reg;

  logic [BCD_W-1:0]   digits_adj;
  logic [REG_W-1:0]   shift_next;
  logic [BCD_W-1:0]   bcd_next;
  logic               ovf_next;

  // Digit field sits above the binary field; every digit is adjusted in
  // parallel before the single-bit shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (shift_reg[BIN_WIDTH + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (digits_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The top bit falls off the register: a carry out of the most significant
  // digit is discarded, leaving the value modulo 10**DIGITS.
  assign shift_next = {digits_adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1:0], 1'b0};

  assign ovf_next = ({{(32-BIN_WIDTH){1'b0}}, Binary_Number} >= BCD_LIMIT);

`ifdef BCD_SATURATE_EN
  assign bcd_next = ovf_flag_reg ? {DIGITS{BCD_NINE}} : shift_next[REG_W-1 -: BCD_W];
`else
  assign bcd_next = shift_next[REG_W-1 -: BCD_W];
`endif

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      ovf_flag_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            shift_reg    <= {{BCD_W{1'b0}}, Binary_Number};
            cnt_reg      <= '0;
            ovf_flag_reg <= ovf_next;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg + CNT_W'(1);
          // The final shift and the result capture happen on the same edge.
          if (cnt_reg == LAST_CNT) begin
            bcd_reg      <= bcd_next;
            overflow_reg <= ovf_flag_reg;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Busy       = busy_reg;
  assign Done       = done_reg;
  assign BCD_Number = bcd_reg;
  assign Overflow   = overflow_reg;

endmodule : binary_to_bcd_serial
